// File: rtl/lane_align_pkg.sv
// lane_align_pkg: shared state encoding and position constants for lane alignment
package lane_align_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL} state_t;
    localparam int BEATS_PER_WORD = 2;
    localparam int SLIPS_PER_BEAT = 6;
    localparam int POS_MAX = BEATS_PER_WORD * SLIPS_PER_BEAT - 1;
endpackage

// File: rtl/lane_align_lane.sv
// lane_align_lane: per-lane mismatch tracking, slip position, phase select and bitslip pulse
module lane_align_lane
    import lane_align_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 'h0F3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clear,
    input  logic             win_start,
    input  logic             check,
    input  logic             win_end,
    input  logic             slip,
    input  logic             word_phase,
    input  logic [WIDTH-1:0] data,
    output logic             bitslip,
    output logic             phase_sel,
    output logic             lane_ok,
    output logic             pass,
    output logic [3:0]       pos
);
    logic mism;
    logic hit_bad;

    assign hit_bad = check && (word_phase == phase_sel) && (data != TRAIN_PATTERN);
    assign pass = !mism && !hit_bad;

    // window bookkeeping; the final window cycle's sample is folded in through pass
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bitslip   <= 1'b0;
            phase_sel <= 1'b0;
            lane_ok   <= 1'b0;
            mism      <= 1'b0;
            pos       <= '0;
        end else begin
            bitslip <= slip && !lane_ok;
            if (clear) begin
                phase_sel <= 1'b0;
                lane_ok   <= 1'b0;
                mism      <= 1'b0;
                pos       <= '0;
            end else begin
                mism <= win_start ? 1'b0 : (mism | hit_bad);
                if (win_end && pass)
                    lane_ok <= 1'b1;
                if (slip && !lane_ok) begin
                    pos       <= pos + 4'd1;
                    phase_sel <= (pos + 4'd1) >= 4'(SLIPS_PER_BEAT);
                end
            end
        end
    end
endmodule

// File: rtl/lane_align_ctrl.sv
// lane_align_ctrl: training FSM sequencing bitslip and phase select until all lanes match; LANE_ALIGN_STATS_EN adds slip_pos and retrain_cnt
module lane_align_ctrl
    import lane_align_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 12,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 'h0F3,
    parameter int SETTLE_CYCLES = 8,
    parameter int MATCH_COUNT = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   start,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   word_phase,
    output logic [LANES-1:0]       bitslip,
    output logic [LANES-1:0]       phase_sel,
    output logic [LANES-1:0]       lane_ok,
    output logic                   busy,
    output logic                   locked,
`ifdef LANE_ALIGN_STATS_EN
    output logic [LANES*4-1:0]     slip_pos,
    output logic [7:0]             retrain_cnt,
`endif
    output logic                   fail
);
    state_t state;
    logic [8:0] cnt;
    logic start_q;
    logic clear, win_start, win_end, check, slip;
    logic all_ok, any_fail;
    logic [LANES-1:0] pass, at_max;
    logic [3:0] pos [LANES];

    assign clear = start && (state == IDLE || ((state == LOCKED || state == FAIL) && !start_q));
    assign win_start = state == SETTLE && cnt == 9'(SETTLE_CYCLES - 1);
    assign win_end = state == CHECK && cnt == 9'(2 * MATCH_COUNT - 1);
    assign check = state == CHECK;
    assign slip = state == SLIP;
    assign all_ok = &(lane_ok | pass);
    assign any_fail = |(~(lane_ok | pass) & at_max);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_align_lane #(.WIDTH(WIDTH), .TRAIN_PATTERN(TRAIN_PATTERN)) u_lane (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .clear      (clear),
            .win_start  (win_start),
            .check      (check),
            .win_end    (win_end),
            .slip       (slip),
            .word_phase (word_phase),
            .data       (in_data[i*WIDTH +: WIDTH]),
            .bitslip    (bitslip[i]),
            .phase_sel  (phase_sel[i]),
            .lane_ok    (lane_ok[i]),
            .pass       (pass[i]),
            .pos        (pos[i])
        );
        assign at_max[i] = pos[i] == 4'(POS_MAX);
`ifdef LANE_ALIGN_STATS_EN
        assign slip_pos[i*4 +: 4] = pos[i];
`endif
    end

    // training sequencer with registered status flags; start only matters in IDLE/LOCKED/FAIL
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            busy    <= 1'b0;
            locked  <= 1'b0;
            fail    <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, LOCKED, FAIL: begin
                    if (clear) begin
                        state  <= SETTLE;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        locked <= 1'b0;
                        fail   <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt   <= win_start ? 9'd0 : cnt + 9'd1;
                    state <= win_start ? CHECK : SETTLE;
                end
                CHECK: begin
                    cnt <= win_end ? 9'd0 : cnt + 9'd1;
                    if (win_end) begin
                        state  <= all_ok ? LOCKED : any_fail ? FAIL : SLIP;
                        locked <= all_ok;
                        fail   <= !all_ok && any_fail;
                        busy   <= !all_ok && !any_fail;
                    end
                end
                SLIP: state <= SETTLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LANE_ALIGN_STATS_EN
    // saturating count of trainings started, cleared only by reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            retrain_cnt <= '0;
        else if (clear && retrain_cnt != 8'hFF)
            retrain_cnt <= retrain_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_lane_align_ctrl.sv
// tb_lane_align_ctrl: scoreboard bench with a rotating-word lane model reacting to bitslip
module tb_lane_align_ctrl;
    localparam int S = 8;
    localparam int M = 16;
    localparam logic [11:0] PAT = 12'h0F3;

    typedef struct packed {
        logic [15:0] slips;
        logic [3:0]  ok;
        logic [3:0]  ph;
        logic        lk;
        logic        fl;
        logic [9:0]  lat;
    } exp_t;

    logic sys_clk, sys_rst, start, word_phase, busy, locked, fail;
    logic [47:0] in_data;
    logic [3:0] bitslip, phase_sel, lane_ok, prev_bs;
`ifdef LANE_ALIGN_STATS_EN
    logic [15:0] slip_pos;
    logic [7:0] retrain_cnt;
`endif

    int tests = 0, fails = 0, nstart = 0;
    int tgt [4];
    int pulses [4];
    int base [4];
    logic corrupt;
    exp_t sb [$];

    lane_align_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .in_data(in_data),
        .word_phase(word_phase), .bitslip(bitslip), .phase_sel(phase_sel),
        .lane_ok(lane_ok), .busy(busy), .locked(locked),
`ifdef LANE_ALIGN_STATS_EN
        .slip_pos(slip_pos), .retrain_cnt(retrain_cnt),
`endif
        .fail(fail)
    );

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] rotl(input logic [11:0] v, input int k);
        logic [23:0] w;
        w = {v, v} << k;
        return w[23:12];
    endfunction

    function automatic int lat(input int w);
        return w * (S + 2 * M) + w - 1;
    endfunction

    function automatic exp_t mk(input logic [15:0] sl, input logic [3:0] ok, input logic [3:0] ph,
                                input logic lk, input logic fl, input int l);
        exp_t e;
        e.slips = sl; e.ok = ok; e.ph = ph; e.lk = lk; e.fl = fl; e.lat = 10'(l);
        return e;
    endfunction

    // lane model: word is the pattern rotated by the slips still missing; 14 never matches, 15 always matches
    always_comb begin
        in_data = '0;
        for (int i = 0; i < 4; i++) begin
            int d;
            logic [11:0] w;
            d = pulses[i] - base[i];
            w = tgt[i] >= 15 ? PAT : tgt[i] >= 12 ? 12'h555 : rotl(PAT, ((tgt[i] - d) % 12 + 12) % 12);
            in_data[i*12 +: 12] = (i == 3 && corrupt) ? 12'h000 : w;
        end
    end

    // monitor: count slip pulses, check pulse spacing and phase_sel against slip count
    always @(negedge sys_clk) begin
        word_phase = ~word_phase;
        if (bitslip != 0)
            chk("bitslip_gap", {28'd0, bitslip & prev_bs}, 0);
        for (int i = 0; i < 4; i++)
            if (bitslip[i]) begin
                pulses[i]++;
                chk("phase_with_slip", {31'd0, phase_sel[i]}, {31'd0, (pulses[i] - base[i]) >= 6});
            end
        prev_bs = bitslip;
    end

    task automatic go(input logic hold, input logic push, input exp_t e);
        start = 0;
        @(posedge sys_clk); #1;
        for (int i = 0; i < 4; i++) base[i] = pulses[i];
        start = 1;
        @(posedge sys_clk); #1;
        nstart = nstart < 255 ? nstart + 1 : 255;
        if (push) sb.push_back(e);
        chk("busy_on_start", {31'd0, busy}, 1);
        chk("locked_cleared", {31'd0, locked}, 0);
        chk("phase_cleared", {28'd0, phase_sel}, 0);
        chk("ok_cleared", {28'd0, lane_ok}, 0);
`ifdef LANE_ALIGN_STATS_EN
        chk("retrain_cnt", {24'd0, retrain_cnt}, nstart);
`endif
        if (!hold) start = 0;
    endtask

    task automatic finish_run(input logic inj);
        int n;
        exp_t e;
        n = 0;
        while (!(locked | fail) && n < 1000) begin
            @(posedge sys_clk); #1;
            n++;
            corrupt = inj && (n == S + 2 * M - 2 || n == S + 2 * M - 1);
        end
        corrupt = 0;
        e = sb.pop_front();
        chk("latency", n, {22'd0, e.lat});
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("slips_lane%0d", i), pulses[i] - base[i], {28'd0, e.slips[i*4 +: 4]});
`ifdef LANE_ALIGN_STATS_EN
            chk($sformatf("slip_pos_lane%0d", i), {28'd0, slip_pos[i*4 +: 4]}, {28'd0, e.slips[i*4 +: 4]});
`endif
        end
        chk("locked", {31'd0, locked}, {31'd0, e.lk});
        chk("fail", {31'd0, fail}, {31'd0, e.fl});
        chk("busy_done", {31'd0, busy}, 0);
        chk("lane_ok", {28'd0, lane_ok}, {28'd0, e.ok});
        chk("phase_sel", {28'd0, phase_sel}, {28'd0, e.ph});
    endtask

    task automatic set_tgt(input int a, input int b, input int c, input int d);
        tgt[0] = a; tgt[1] = b; tgt[2] = c; tgt[3] = d;
    endtask

    initial begin
        word_phase = 0; prev_bs = 0; corrupt = 0; start = 0; sys_rst = 1;
        for (int i = 0; i < 4; i++) begin tgt[i] = 0; pulses[i] = 0; base[i] = 0; end
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_fail", {31'd0, fail}, 0);
        chk("rst_lane_ok", {28'd0, lane_ok}, 0);
        chk("rst_phase", {28'd0, phase_sel}, 0);
        chk("rst_bitslip", {28'd0, bitslip}, 0);

        set_tgt(0, 0, 0, 0);
        go(1, 1, mk(16'h0000, 4'hF, 4'h0, 1, 0, lat(1)));
        finish_run(0);
        repeat (5) @(posedge sys_clk);
        #1 chk("held_start_locked", {31'd0, locked}, 1);
        chk("held_start_busy", {31'd0, busy}, 0);

        set_tgt(0, 0, 3, 0);
        go(0, 1, mk(16'h0300, 4'hF, 4'h0, 1, 0, lat(4)));
        finish_run(0);

        set_tgt(7, 0, 0, 0);
        go(0, 1, mk(16'h0007, 4'hF, 4'h1, 1, 0, lat(8)));
        finish_run(0);

        set_tgt(0, 0, 0, 0);
        go(0, 1, mk(16'h0000, 4'hF, 4'h0, 1, 0, lat(1)));
        finish_run(0);

        set_tgt(0, 14, 0, 0);
        go(0, 1, mk(16'h00B0, 4'hD, 4'h2, 0, 1, lat(12)));
        finish_run(0);

        set_tgt(0, 0, 0, 15);
        go(0, 1, mk(16'h1000, 4'hF, 4'h0, 1, 0, lat(2)));
        finish_run(1);

        set_tgt(0, 0, 3, 0);
        go(0, 0, mk(16'h0000, 4'h0, 4'h0, 0, 0, 0));
        repeat (S + 2 * M - 1) @(posedge sys_clk);
        #1 sys_rst = 1;
        @(posedge sys_clk); #1;
        sys_rst = 0;
        nstart = 0;
        chk("abort_bitslip", {28'd0, bitslip}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_lane_ok", {28'd0, lane_ok}, 0);
        chk("abort_locked", {31'd0, locked}, 0);
        chk("abort_fail", {31'd0, fail}, 0);
`ifdef LANE_ALIGN_STATS_EN
        chk("abort_retrain_cnt", {24'd0, retrain_cnt}, 0);
        chk("abort_slip_pos", {16'd0, slip_pos}, 0);
`endif
        repeat (3) @(posedge sys_clk);
        #1 chk("idle_after_abort", {31'd0, busy}, 0);

        go(0, 1, mk(16'h0300, 4'hF, 4'h0, 1, 0, lat(4)));
        finish_run(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
